// File: rtl/brcomp_iter.sv
// brcomp_iter: iterative branch comparator. It compares two captured operands
// one SLICE-wide chunk per cycle, most significant slice first, and stops at
// the first slice that differs.
//
// Handshake: a request transfers on a rising edge where valid_i && ready_o.
// A result transfers on a rising edge where valid_o && ready_i. The producer
// of valid holds it and its data until that transfer. flush_i overrides both
// transfers on the edge where it is high.
module brcomp_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    input  logic             br_unsigned_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             br_less_o,
    output logic             br_equal_o,
    output logic [1:0]       dbg_state
);

    // SLICE_SAFE keeps the derived parameters computable so that the
    // parameter check below can report a bad SLICE.
    localparam int SLICE_SAFE = (SLICE < 1) ? 1 : SLICE;
    localparam int NSLICE     = WIDTH / SLICE_SAFE;
    localparam int IDXW       = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    // Reject operand widths that do not split into whole slices.
    generate
        if ((SLICE < 1) || ((WIDTH % SLICE_SAFE) != 0) || (NSLICE < 1)) begin : g_param_check
            $error("brcomp_iter: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  rs1_q, rs1_d;
    logic [WIDTH-1:0]  rs2_q, rs2_d;
    logic              uns_q, uns_d;
    logic              less_q, less_d;
    logic              eq_q, eq_d;

    logic [WIDTH-1:0]  op1, op2;
    logic [SLICE_SAFE-1:0] slice1, slice2;

    // Select the current slice; signed mode flips both sign bits so that an
    // unsigned compare of the top slice gives the two's-complement order.
    always_comb begin
        op1 = rs1_q;
        op2 = rs2_q;
        if (!uns_q) begin
            op1[WIDTH-1] = ~rs1_q[WIDTH-1];
            op2[WIDTH-1] = ~rs2_q[WIDTH-1];
        end
        slice1 = op1[32'(idx_q) * SLICE_SAFE +: SLICE_SAFE];
        slice2 = op2[32'(idx_q) * SLICE_SAFE +: SLICE_SAFE];
    end

    // Next-state and register updates; flush wins over every other transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        uns_d   = uns_q;
        less_d  = less_q;
        eq_d    = eq_q;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = IDX_TOP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        rs1_d   = rs1_data_i;
                        rs2_d   = rs2_data_i;
                        uns_d   = br_unsigned_i;
                        idx_d   = IDX_TOP;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (slice1 != slice2) begin
                        less_d  = (slice1 < slice2);
                        eq_d    = 1'b0;
                        state_d = DONE;
                    end else if (idx_q == '0) begin
                        less_d  = 1'b0;
                        eq_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            rs1_q   <= '0;
            rs2_q   <= '0;
            uns_q   <= 1'b0;
            less_q  <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            uns_q   <= uns_d;
            less_q  <= less_d;
            eq_q    <= eq_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign br_less_o  = less_q;
    assign br_equal_o = eq_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_brcomp_iter.sv
module tb_brcomp_iter;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] rs1_data_i;
    logic [WIDTH-1:0] rs2_data_i;
    logic             br_unsigned_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic             br_less_o;
    logic             br_equal_o;
    logic [1:0]       dbg_state;

    brcomp_iter #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .br_unsigned_i (br_unsigned_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .br_less_o     (br_less_o),
        .br_equal_o    (br_equal_o),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    // Expected entry: {latency[5:0], less, equal}
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: ordering from plain signed/unsigned arithmetic; the number of
    // slices examined follows from the highest differing bit.
    function automatic logic [7:0] model(input logic [31:0] a, input logic [31:0] b, input logic uns);
        logic        less;
        logic [31:0] x;
        int          k;
        logic        found;
        less  = uns ? (a < b) : ($signed(a) < $signed(b));
        x     = a ^ b;
        k     = NSLICE;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                k     = NSLICE - (i / SLICE);
                found = 1'b1;
            end
        end
        return {6'(k + 1), less, (x == 32'd0)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic scramble_inputs();
        rs1_data_i    = $urandom;
        rs2_data_i    = $urandom;
        br_unsigned_i = 1'($urandom_range(0, 1));
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic mode,
                           input int hold, input string tag);
        int         lat;
        logic [7:0] exp;
        logic       r_less;
        logic       r_eq;
        @(negedge clk_i);
        check({tag, "_ready_idle"}, ready_o, 1);
        valid_i       = 1'b1;
        rs1_data_i    = a;
        rs2_data_i    = b;
        br_unsigned_i = mode;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        scramble_inputs();
        check({tag, "_ready_busy"}, ready_o, 0);
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
            scramble_inputs();
        end
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
            exp = 8'd0;
        end else begin
            exp = exp_q.pop_front();
        end
        if (!valid_o) begin
            check({tag, "_timeout"}, valid_o, 1);
        end else begin
            r_less = br_less_o;
            r_eq   = br_equal_o;
            check({tag, "_latency"}, lat, 32'(exp[7:2]));
            check({tag, "_less"}, r_less, exp[1]);
            check({tag, "_equal"}, r_eq, exp[0]);
            check({tag, "_exclusive"}, r_less & r_eq, 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk_i);
                ready_i = 1'b0;
                scramble_inputs();
                @(posedge clk_i); #1;
                check({tag, "_hold_valid"}, valid_o, 1);
                check({tag, "_hold_less"}, br_less_o, r_less);
                check({tag, "_hold_equal"}, br_equal_o, r_eq);
                check({tag, "_hold_ready"}, ready_o, 0);
            end
            @(negedge clk_i);
            ready_i = 1'b1;
            @(posedge clk_i); #1;
            ready_i = 1'b0;
            check({tag, "_after_valid"}, valid_o, 0);
            check({tag, "_after_ready"}, ready_o, 1);
        end
    endtask

    // Accept a request and leave the block in its first BUSY cycle.
    task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic mode);
        @(negedge clk_i);
        valid_i       = 1'b1;
        rs1_data_i    = a;
        rs2_data_i    = b;
        br_unsigned_i = mode;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic watch_no_valid(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i); #1;
            if (valid_o) seen = 1'b1;
        end
        check({tag, "_no_valid"}, seen, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        uns;
        int          hold;
        logic        less;
        logic        eq;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // hand-derived expectations
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3, 1'b1, 1'b0, 2};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, 1'b0, 1'b0, 2};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1, 1'b0, 1'b1, 5};
        vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 0, 1'b0, 1'b1, 5};
        vecs[4] = '{32'h0000_0010, 32'h0000_0011, 1'b0, 0, 1'b1, 1'b0, 5};
        vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 1'b1, 1'b0, 2};
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2, 1'b0, 1'b0, 2};
        vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 1'b0, 2};
        vecs[8] = '{32'h0000_FF00, 32'h0000_00FF, 1'b1, 0, 1'b0, 1'b0, 4};

        rst_ni        = 1'b0;
        valid_i       = 1'b0;
        rs1_data_i    = '0;
        rs2_data_i    = '0;
        br_unsigned_i = 1'b0;
        flush_i       = 1'b0;
        ready_i       = 1'b0;

        // reset state
        repeat (2) @(negedge clk_i);
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_less", br_less_o, 0);
        check("rst_equal", br_equal_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("rel_ready", ready_o, 1);

        // table
        for (int v = 0; v < 9; v++) begin
            exp_q.push_back({6'(vecs[v].lat), vecs[v].less, vecs[v].eq});
            run_req(vecs[v].rs1, vecs[v].rs2, vecs[v].uns, vecs[v].hold, $sformatf("vec%0d", v));
        end

        // flush together with valid_i in IDLE: no accept
        @(negedge clk_i);
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush_accept_ready", ready_o, 1);
        watch_no_valid(4, "flush_accept");

        // flush in the second BUSY cycle
        start_req(32'h0000_0010, 32'h0000_0011, 1'b0);
        @(posedge clk_i); #1;
        check("flush_busy2_ready", ready_o, 0);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_busy_valid", valid_o, 0);
        check("flush_busy_ready", ready_o, 1);
        watch_no_valid(6, "flush_busy");
        exp_q.push_back(model(32'h0000_0010, 32'h0000_0011, 1'b0));
        run_req(32'h0000_0010, 32'h0000_0011, 1'b0, 0, "post_flush");

        // flush in DONE beats the missing handshake
        start_req(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk_i); #1;
        check("flush_done_valid_pre", valid_o, 1);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush_done_valid", valid_o, 0);
        check("flush_done_ready", ready_o, 1);

        // reset asserted mid-BUSY
        start_req(32'h1234_5678, 32'h1234_5678, 1'b1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_ready", ready_o, 1);
        check("midrst_equal", br_equal_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("midrst_rel_ready", ready_o, 1);
        watch_no_valid(6, "midrst");
        exp_q.push_back(model(32'h8000_0000, 32'h7FFF_FFFF, 1'b0));
        run_req(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, "post_rst");

        // randomized requests against the reference model
        for (int r = 0; r < 60; r++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        mode;
            int          kind;
            a    = $urandom;
            kind = $urandom_range(0, 2);
            if (kind == 0) b = $urandom;
            else if (kind == 1) b = a;
            else b = a ^ (32'd1 << $urandom_range(0, 31));
            mode = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, mode));
            run_req(a, b, mode, $urandom_range(0, 2), $sformatf("rnd%0d", r));
        end

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
